lap_stopwatch: RTL

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/lap_stopwatch.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: minutes:seconds.centiseconds stopwatch with an optional lap (split) display.
// The count is kept directly as six BCD digits and advanced once per 10 ms tick.
// Optional feature macro: LAP_STOPWATCH_LAP_EN enables the LAP state and the snapshot
// registers. Without it, lap is ignored, lap_hold is tied low and the live count is always shown.
module lap_stopwatch #(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int MINUTE_LIMIT = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] m_tens,
  output logic [3:0] m_ones,
  output logic [3:0] s_tens,
  output logic [3:0] s_ones,
  output logic [3:0] c_tens,
  output logic [3:0] c_ones,
  output logic       running,
  output logic       lap_hold,
  output logic       wrap
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 100;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [3:0]    M_LAST_TENS = 4'((MINUTE_LIMIT - 1) / 10);
  localparam logic [3:0]    M_LAST_ONES = 4'((MINUTE_LIMIT - 1) % 10);

  typedef struct packed {
    logic [3:0] m_tens;
    logic [3:0] m_ones;
    logic [3:0] s_tens;
    logic [3:0] s_ones;
    logic [3:0] c_tens;
    logic [3:0] c_ones;
  } bcd_time_t;

  localparam bcd_time_t COUNT_MAX = '{
    m_tens: M_LAST_TENS, m_ones: M_LAST_ONES,
    s_tens: 4'd5, s_ones: 4'd9, c_tens: 4'd9, c_ones: 4'd9
  };

`ifdef LAP_STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`endif

  state_t          state;
  state_t          nxt_state;
  logic [PW-1:0]   prescaler;
  logic [PW-1:0]   nxt_prescaler;
  bcd_time_t       count;
  bcd_time_t       nxt_count;
  bcd_time_t       disp_q;
  bcd_time_t       nxt_disp;
  logic            running_q;
  logic            nxt_running;
  logic            wrap_q;
  logic            nxt_wrap;
  logic            counting;
  logic            tick;

`ifdef LAP_STOPWATCH_LAP_EN
  bcd_time_t       snapshot;
  bcd_time_t       nxt_snapshot;
  logic            lap_hold_q;
  logic            nxt_lap_hold;
`else
  logic            unused_lap;
  assign unused_lap = lap;
`endif

  // Advance a BCD time by one centisecond, rippling carries digit by digit up to the minutes,
  // which roll over to 00 after the last legal minute value.
  function automatic bcd_time_t bcd_increment(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.c_ones != 4'd9) begin
      r.c_ones = t.c_ones + 4'd1;
    end else begin
      r.c_ones = 4'd0;
      if (t.c_tens != 4'd9) begin
        r.c_tens = t.c_tens + 4'd1;
      end else begin
        r.c_tens = 4'd0;
        if (t.s_ones != 4'd9) begin
          r.s_ones = t.s_ones + 4'd1;
        end else begin
          r.s_ones = 4'd0;
          if (t.s_tens != 4'd5) begin
            r.s_tens = t.s_tens + 4'd1;
          end else begin
            r.s_tens = 4'd0;
            if ((t.m_tens == M_LAST_TENS) && (t.m_ones == M_LAST_ONES)) begin
              r.m_tens = 4'd0;
              r.m_ones = 4'd0;
            end else if (t.m_ones != 4'd9) begin
              r.m_ones = t.m_ones + 4'd1;
            end else begin
              r.m_ones = 4'd0;
              r.m_tens = t.m_tens + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // The prescaler and count only move while the stopwatch is running (RUN, or LAP when enabled).
`ifdef LAP_STOPWATCH_LAP_EN
  assign counting = (state == RUN) || (state == LAP);
`else
  assign counting = (state == RUN);
`endif
  assign tick = counting && (prescaler == TICK_LAST);

  // Next-state logic: apply the tick first, then the highest-priority command (clear > start_stop > lap).
  always_comb begin
    nxt_state     = state;
    nxt_prescaler = prescaler;
    nxt_count     = count;
    nxt_wrap      = 1'b0;
`ifdef LAP_STOPWATCH_LAP_EN
    nxt_snapshot  = snapshot;
`endif

    if (counting) begin
      nxt_prescaler = tick ? '0 : prescaler + 1'b1;
    end

    if (tick) begin
      nxt_count = bcd_increment(count);
      nxt_wrap  = (count == COUNT_MAX);
    end

    if (clear) begin
      nxt_state     = IDLE;
      nxt_prescaler = '0;
      nxt_count     = '0;
      nxt_wrap      = 1'b0;
`ifdef LAP_STOPWATCH_LAP_EN
      nxt_snapshot  = '0;
`endif
    end else if (start_stop) begin
      case (state)
        IDLE:    nxt_state = RUN;
        RUN:     nxt_state = PAUSE;
        PAUSE:   nxt_state = RUN;
`ifdef LAP_STOPWATCH_LAP_EN
        LAP:     nxt_state = PAUSE;
`endif
        default: nxt_state = IDLE;
      endcase
    end else if (lap) begin
`ifdef LAP_STOPWATCH_LAP_EN
      // The split taken on a tick edge must show the already-incremented value.
      if ((state == RUN) || (state == LAP)) begin
        nxt_state    = LAP;
        nxt_snapshot = nxt_count;
      end
`endif
    end

`ifdef LAP_STOPWATCH_LAP_EN
    nxt_running  = (nxt_state == RUN) || (nxt_state == LAP);
    nxt_lap_hold = (nxt_state == LAP);
    nxt_disp     = (nxt_state == LAP) ? nxt_snapshot : nxt_count;
`else
    nxt_running  = (nxt_state == RUN);
    nxt_disp     = nxt_count;
`endif
  end

  // State, count, prescaler and every output register update together so a command shows up right after its edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prescaler  <= '0;
      count      <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef LAP_STOPWATCH_LAP_EN
      snapshot   <= '0;
      lap_hold_q <= 1'b0;
`endif
    end else begin
      state      <= nxt_state;
      prescaler  <= nxt_prescaler;
      count      <= nxt_count;
      disp_q     <= nxt_disp;
      running_q  <= nxt_running;
      wrap_q     <= nxt_wrap;
`ifdef LAP_STOPWATCH_LAP_EN
      snapshot   <= nxt_snapshot;
      lap_hold_q <= nxt_lap_hold;
`endif
    end
  end

  assign m_tens  = disp_q.m_tens;
  assign m_ones  = disp_q.m_ones;
  assign s_tens  = disp_q.s_tens;
  assign s_ones  = disp_q.s_ones;
  assign c_tens  = disp_q.c_tens;
  assign c_ones  = disp_q.c_ones;
  assign running = running_q;
  assign wrap    = wrap_q;
`ifdef LAP_STOPWATCH_LAP_EN
  assign lap_hold = lap_hold_q;
`else
  assign lap_hold = 1'b0;
`endif

endmodule
